// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode constants and the operand-loader state encoding.
// The ALU itself decodes the same opcode constants.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OP_WIDTH_DEF   = 6;
    localparam int OPC_W          = 6;

    localparam logic [OPC_W-1:0] OPC_ADD = 6'b100000;
    localparam logic [OPC_W-1:0] OPC_SUB = 6'b100010;
    localparam logic [OPC_W-1:0] OPC_AND = 6'b100100;
    localparam logic [OPC_W-1:0] OPC_OR  = 6'b100101;
    localparam logic [OPC_W-1:0] OPC_XOR = 6'b100110;
    localparam logic [OPC_W-1:0] OPC_NOR = 6'b100111;
    localparam logic [OPC_W-1:0] OPC_SRA = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_SRL = 6'b000010;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        ISSUE   = 2'b11
    } state_e;

    function automatic logic opc_supported(input logic [OPC_W-1:0] code);
        case (code)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
            OPC_XOR, OPC_NOR, OPC_SRA, OPC_SRL: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Board-side bundle: switches and buttons in, latched operands and status out.
interface alu_operand_loader_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OP_WIDTH   = OP_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] sw;
    logic                  btn_a;
    logic                  btn_b;
    logic                  btn_op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [OP_WIDTH-1:0]   op_code;
    logic                  start;
    logic [1:0]            state;
    logic                  err;

    modport master (
        output sw, btn_a, btn_b, btn_op,
        input  op_a, op_b, op_code, start, state, err
    );

    modport slave (
        input  sw, btn_a, btn_b, btn_op,
        output op_a, op_b, op_code, start, state, err
    );
endinterface

// File: rtl/button_debouncer.sv
// Raw push-button to single-cycle press pulse: 2-FF sync, stability counter,
// rising-edge pulse on the debounced level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    // Any sample matching the stable level restarts the run of differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == TC) begin
                stable_d = sync_q;
                press_d  = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and opcode from switches on debounced button
// presses, then issues them to the ALU with a one-cycle start pulse.
//
//   state   | meaning
//   LOAD_A  | waiting for btn_a to capture operand A
//   LOAD_B  | waiting for btn_b to capture operand B
//   LOAD_OP | waiting for btn_op with a supported opcode
//   ISSUE   | start high for one cycle, then back to LOAD_A
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int OP_WIDTH        = OP_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                 clk,
    input logic                 reset,
    alu_operand_loader_if.slave bus
);
    logic                  press_a, press_b, press_op;
    logic [DATA_WIDTH-1:0] sw_meta_q, sw_sync_q;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [OP_WIDTH-1:0]   op_code_q, op_code_d;
    logic                  err_q, err_d;
    logic [OP_WIDTH-1:0]   sw_code;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .btn_i(bus.btn_a), .press_o(press_a)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .btn_i(bus.btn_b), .press_o(press_b)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .clk(clk), .reset(reset), .btn_i(bus.btn_op), .press_o(press_op)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            state_q   <= LOAD_A;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= bus.sw;
            sw_sync_q <= sw_meta_q;
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            err_q     <= err_d;
        end
    end

    assign sw_code = sw_sync_q[OP_WIDTH-1:0];

    // Only the button matching the current state is honoured; the rest are dropped.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        err_d     = err_q;
        case (state_q)
            LOAD_A: begin
                if (press_a) begin
                    op_a_d  = sw_sync_q;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press_b) begin
                    op_b_d  = sw_sync_q;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press_op) begin
                    if (opc_supported(OPC_W'(sw_code))) begin
                        op_code_d = sw_code;
                        err_d     = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE:   state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    assign bus.op_a    = op_a_q;
    assign bus.op_b    = op_b_q;
    assign bus.op_code = op_code_q;
    assign bus.err     = err_q;
    assign bus.state   = state_q;
    assign bus.start   = (state_q == ISSUE);
endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the operand width.
REQ-002 Parameter OP_WIDTH, default 6, SHALL set the opcode width.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, SHALL set the number of consecutive stable samples required to accept a button level; benches set it to 4.
REQ-004 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset  input  1  SHALL be synchronous and active-high.
REQ-006 sw  input  DATA_WIDTH  SHALL carry the operand/opcode value from the board switches; asynchronous.
REQ-007 btn_a, btn_b, btn_op  input  1 each  SHALL be raw, asynchronous, bouncing push-button levels.
REQ-008 op_a, op_b  output  DATA_WIDTH  SHALL present the latched ALU operands.
REQ-009 op_code  output  OP_WIDTH  SHALL present the latched ALU opcode.
REQ-010 start  output  1  SHALL pulse high for exactly one cycle when a complete operand set is issued.
REQ-011 state  output  2  SHALL expose the FSM encoding for LEDs.
REQ-012 err  output  1  SHALL be high while the last opcode press held an unsupported code.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a debouncer whose stable level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample SHALL restart the count.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced level's 0->1 transition; releases generate no event.
REQ-015 sw SHALL be sampled through a 2-FF synchronizer; the value captured is the synchronized sw in the press-event cycle.
REQ-016 FSM states SHALL be LOAD_A (2'b00), LOAD_B (2'b01), LOAD_OP (2'b10), ISSUE (2'b11).
REQ-017 LOAD_A: btn_a event SHALL latch op_a and go to LOAD_B; other events ignored.
REQ-018 LOAD_B: btn_b event SHALL latch op_b and go to LOAD_OP; other events ignored.
REQ-019 LOAD_OP: btn_op event with a supported code SHALL latch op_code = sw[OP_WIDTH-1:0], clear err and go to ISSUE.
REQ-020 LOAD_OP: btn_op event with unsupported code SHALL set err, leave op_code unchanged, stay in LOAD_OP.
REQ-021 Supported codes SHALL be ADD 6'b100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
REQ-022 ISSUE SHALL assert start for one cycle and return to LOAD_A next cycle unconditionally; events arriving in ISSUE are discarded.
REQ-023 Latched outputs SHALL hold their values until overwritten by a later accepted press; start-to-op stability is guaranteed (op_* stable during the start cycle).
REQ-024 Simultaneous events in one cycle SHALL be resolved by state: only the button matching the current state is acted on.
REQ-025 Latency from a clean button edge to the latch SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles, fixed.
REQ-026 A button held continuously SHALL produce one event only.

Reset
REQ-027 While reset is high at a clock edge: state=LOAD_A, op_a=0, op_b=0, op_code=0, start=0, err=0, debouncer stable levels=0, counters=0, synchronizers=0.
REQ-028 Reset mid-sequence SHALL discard partial loads; a button held through reset release SHALL register as a press once debounced.

Structure
REQ-029 Shared package alu_pkg SHALL hold DATA_WIDTH/OP_WIDTH defaults, the opcode constants of REQ-021 and the FSM state encoding; ALU_module uses the same opcode constants.
REQ-030 Sub-module button_debouncer (synchronizer + counter + edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 sw=8'h05 press btn_a, sw=8'h03 press btn_b, sw=8'h20 press btn_op -> op_a=05, op_b=03, op_code=100000, one start pulse, state back to 00.
REQ-032 btn_a toggling every cycle for 10 cycles then held high -> exactly one event, op_a latched once.
REQ-033 In LOAD_A press btn_b and btn_op -> no state change, op_b/op_code stay 0.
REQ-034 In LOAD_OP press btn_op with sw=8'h3F -> err=1, state stays 10; then sw=8'h22 press -> err=0, op_code=100010, start pulse.
REQ-035 Assert reset while in LOAD_OP after op_a=AA, op_b=55 -> all outputs 0, state 00 next cycle.
REQ-036 Clean btn_a edge -> op_a updates exactly 7 cycles later; start never exceeds one cycle.
